// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART command engine: command codes seen on the
// core's UARTC pins, the engine state type, and small command decoders.
package uart_link_pkg;

  localparam logic [2:0] UARTC_NOP     = 3'b000;
  localparam logic [2:0] UARTC_TX_BYTE = 3'b001;
  localparam logic [2:0] UARTC_RX_BYTE = 3'b010;
  localparam logic [2:0] UARTC_TX_WORD = 3'b011;
  localparam logic [2:0] UARTC_RX_WORD = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_BITS,
    ST_RX_HUNT,
    ST_RX_BITS,
    ST_DONE
  } state_t;

  // Codes 101..111 are treated as NOP
  function automatic logic cmd_valid(input logic [2:0] c);
    return (c == UARTC_TX_BYTE) || (c == UARTC_RX_BYTE) ||
           (c == UARTC_TX_WORD) || (c == UARTC_RX_WORD);
  endfunction

  function automatic logic cmd_is_rx(input logic [2:0] c);
    return (c == UARTC_RX_BYTE) || (c == UARTC_RX_WORD);
  endfunction

  function automatic logic cmd_is_word(input logic [2:0] c);
    return (c == UARTC_TX_WORD) || (c == UARTC_RX_WORD);
  endfunction

endpackage

// File: rtl/uart_link_if.sv
// Core-side UART command bus: command/write value from the core, completion,
// received data and status back from the engine.
interface uart_link_if;
  logic [2:0]  uartc;
  logic [31:0] write_value;
  logic        wb_flag;
  logic [31:0] wb_data;
  logic        frame_err;
  logic        busy;

  modport master (
    output uartc, write_value,
    input  wb_flag, wb_data, frame_err, busy
  );

  modport slave (
    input  uartc, write_value,
    output wb_flag, wb_data, frame_err, busy
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle tick a full or half bit period
// after each load. Shared by the TX and RX paths.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam logic [15:0] FULL_COUNT = 16'(CLKS_PER_BIT);
  localparam logic [15:0] HALF_COUNT = 16'(CLKS_PER_BIT / 2);

  logic [15:0] count;

  // Count down to zero after a load; a load on the tick cycle restarts cleanly
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= half ? HALF_COUNT : FULL_COUNT;
    else if (count != '0)
      count <= count - 16'd1;
  end

  assign tick = (count == 16'd1);

endmodule

// File: rtl/uart_link.sv
// UART engine answering the core's 3-bit command bus: 8N1 byte/word transmit
// and receive, level handshake completion via wb_flag.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  uart_link_if.slave  core,
  input  logic        rx,
  output logic        tx
);

  state_t      state, state_next;
  logic [2:0]  cmd;
  logic [31:0] tx_data;
  logic [31:0] rx_word;
  logic [7:0]  rx_byte;
  logic [3:0]  bit_idx;
  logic [2:0]  bytes_left;
  logic        hunt_arm;
  logic        rx_meta, rx_s;
  logic        tx_bit;
  logic        timer_load, timer_half, tick;
  logic        wb_flag_q, frame_err_q, busy_q;
  logic [31:0] wb_data_q;

  assign core.wb_flag   = wb_flag_q;
  assign core.wb_data   = wb_data_q;
  assign core.frame_err = frame_err_q;
  assign core.busy      = busy_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .half  (timer_half),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and bit-timer control
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_half = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid(core.uartc)) begin
          state_next = cmd_is_rx(core.uartc) ? ST_RX_HUNT : ST_TX_BITS;
          timer_load = !cmd_is_rx(core.uartc);
        end
      end
      ST_TX_BITS: begin
        if (tick) begin
          if (bit_idx == 4'd9 && bytes_left == 3'd1) state_next = ST_DONE;
          else                                       timer_load = 1'b1;
        end
      end
      ST_RX_HUNT: begin
        if (!hunt_arm && !rx_s) begin
          timer_load = 1'b1;
          timer_half = 1'b1;
        end else if (hunt_arm && tick && !rx_s) begin
          state_next = ST_RX_BITS;
          timer_load = 1'b1;
        end
      end
      ST_RX_BITS: begin
        if (tick) begin
          if (bit_idx == 4'd8)
            state_next = (bytes_left == 3'd1) ? ST_DONE : ST_RX_HUNT;
          else
            timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        if (core.uartc == UARTC_NOP) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Serial output bit for the current frame position (start, 8 data LSB first, stop)
  always_comb begin
    tx_bit = 1'b1;
    if (state == ST_TX_BITS) begin
      if (bit_idx == 4'd0)      tx_bit = 1'b0;
      else if (bit_idx <= 4'd8) tx_bit = tx_data[3'(bit_idx - 4'd1)];
    end
  end

  // Datapath and registered outputs. wb_flag/busy look at both current and next
  // state so they rise one edge after entry yet fall on the very edge that
  // leaves DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd         <= UARTC_NOP;
      tx_data     <= '0;
      rx_word     <= '0;
      rx_byte     <= '0;
      bit_idx     <= '0;
      bytes_left  <= '0;
      hunt_arm    <= 1'b0;
      tx          <= 1'b1;
      wb_flag_q   <= 1'b0;
      wb_data_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx        <= tx_bit;
      busy_q    <= (state != ST_IDLE) && (state_next != ST_IDLE);
      wb_flag_q <= (state == ST_DONE) && (state_next == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (cmd_valid(core.uartc)) begin
            cmd        <= core.uartc;
            tx_data    <= core.write_value;
            bytes_left <= cmd_is_word(core.uartc) ? 3'd4 : 3'd1;
            bit_idx    <= '0;
            hunt_arm   <= 1'b0;
            if (cmd_is_rx(core.uartc)) frame_err_q <= 1'b0;
          end
        end
        ST_TX_BITS: begin
          if (tick) begin
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (bytes_left != 3'd1) begin
                bytes_left <= bytes_left - 3'd1;
                tx_data    <= tx_data >> 8;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_RX_HUNT: begin
          if (!hunt_arm && !rx_s) begin
            hunt_arm <= 1'b1;
          end else if (hunt_arm && tick) begin
            hunt_arm <= 1'b0;
            bit_idx  <= '0;
          end
        end
        ST_RX_BITS: begin
          if (tick) begin
            if (bit_idx == 4'd8) begin
              frame_err_q <= frame_err_q | ~rx_s;
              rx_word     <= {rx_byte, rx_word[31:8]};
              bytes_left  <= bytes_left - 3'd1;
              bit_idx     <= '0;
              hunt_arm    <= 1'b0;
            end else begin
              rx_byte <= {rx_s, rx_byte[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_DONE: begin
          // Bytes shift in from the top, so a single byte ends up in [31:24]
          if (!wb_flag_q && cmd_is_rx(cmd))
            wb_data_q <= cmd_is_word(cmd) ? rx_word : {24'd0, rx_word[31:24]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_link.sv
// Directed testbench for uart_link with CLKS_PER_BIT = 4.
module tb_uart_link;
  import uart_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;
  int   n_cmp = 0;
  int   n_mis = 0;

  uart_link_if bus ();

  uart_link #(.CLKS_PER_BIT(4)) dut (
    .clock (clk),
    .reset (rst),
    .core  (bus),
    .rx    (rx),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_flag(input int limit);
    for (int i = 0; i < limit && !bus.wb_flag; i++) wait_cycles(1);
    check("wb_flag_timeout", {31'd0, bus.wb_flag}, 32'd1);
  endtask

  task automatic drop_cmd();
    bus.uartc = UARTC_NOP;
    wait_cycles(1);
    check("wb_flag_clear", {31'd0, bus.wb_flag}, 32'd0);
    check("busy_clear", {31'd0, bus.busy}, 32'd0);
  endtask

  // Issue a TX command and check every serial cycle plus completion timing
  task automatic tx_cmd(input logic [2:0] code, input logic [31:0] value, input int nbytes);
    logic [7:0] byt;
    logic       exp;
    int         b;
    int         lows;
    bus.uartc       = code;
    bus.write_value = value;
    wait_cycles(1);                        // accept edge E
    bus.write_value = 32'hFFFF_FFFF;       // must not matter after accept
    for (int i = 0; i < nbytes * 40; i++) begin
      wait_cycles(1);                      // sample after edge E+1+i
      byt = 8'(value >> (8 * (i / 40)));
      b   = (i % 40) / 4;
      if (b == 0)      exp = 1'b0;
      else if (b == 9) exp = 1'b1;
      else             exp = byt[b-1];
      check("tx_bit", {31'd0, tx}, {31'd0, exp});
      if (i == 0) check("busy_rise", {31'd0, bus.busy}, 32'd1);
      if (i == nbytes * 40 - 1) check("wb_flag_early", {31'd0, bus.wb_flag}, 32'd0);
    end
    wait_cycles(1);                        // edge E+1+40*nbytes
    check("wb_flag_rise", {31'd0, bus.wb_flag}, 32'd1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (!tx || !bus.wb_flag) lows++;
    end
    check("no_retrigger", lows, 0);
    drop_cmd();
  endtask

  // Drive one 8N1 frame on rx with a chosen stop-bit level
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cycles(4);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      wait_cycles(4);
    end
    rx = stop;
    wait_cycles(4);
    rx = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx_bytes [4];
    int         act;
    rx_bytes[0] = 8'hEF; rx_bytes[1] = 8'hBE; rx_bytes[2] = 8'hAD; rx_bytes[3] = 8'hDE;
    bus.uartc       = UARTC_NOP;
    bus.write_value = '0;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_wb_flag", {31'd0, bus.wb_flag}, 32'd0);
    check("reset_wb_data", bus.wb_data, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);

    act = 0;
    for (int i = 0; i < 50; i++) begin
      wait_cycles(1);
      if (!tx || bus.busy || bus.wb_flag) act++;
    end
    check("idle_quiet", act, 0);

    // Unused code behaves as NOP
    bus.uartc = 3'b110;
    wait_cycles(5);
    check("bad_code_busy", {31'd0, bus.busy}, 32'd0);
    bus.uartc = UARTC_NOP;
    wait_cycles(1);

    tx_cmd(UARTC_TX_BYTE, 32'h0000_00A5, 1);
    check("tx_keeps_wb_data", bus.wb_data, 32'd0);

    tx_cmd(UARTC_TX_WORD, 32'h1122_3344, 4);

    // RX_WORD with random inter-byte gaps
    bus.uartc = UARTC_RX_WORD;
    wait_cycles(2);
    for (int k = 0; k < 4; k++) begin
      rx_frame(rx_bytes[k], 1'b1);
      wait_cycles($urandom_range(0, 7));
    end
    wait_flag(100);
    check("rx_word_data", bus.wb_data, 32'hDEAD_BEEF);
    check("rx_word_frame_err", {31'd0, bus.frame_err}, 32'd0);
    drop_cmd();

    // RX_BYTE: glitch ignored, then a frame with a bad stop bit
    bus.uartc = UARTC_RX_BYTE;
    wait_cycles(2);
    rx = 1'b0;
    wait_cycles(1);
    rx = 1'b1;
    wait_cycles(12);
    check("glitch_still_busy", {31'd0, bus.busy}, 32'd1);
    check("glitch_no_flag", {31'd0, bus.wb_flag}, 32'd0);
    check("glitch_wb_data", bus.wb_data, 32'hDEAD_BEEF);
    rx_frame(8'h3C, 1'b0);
    wait_flag(50);
    check("rx_byte_data", bus.wb_data, 32'h0000_003C);
    check("rx_byte_frame_err", {31'd0, bus.frame_err}, 32'd1);
    drop_cmd();

    // Next RX command clears frame_err on accept
    bus.uartc = UARTC_RX_BYTE;
    wait_cycles(1);
    check("frame_err_cleared", {31'd0, bus.frame_err}, 32'd0);
    wait_cycles(1);
    rx_frame(8'h5A, 1'b1);
    wait_flag(50);
    check("rx_byte2_data", bus.wb_data, 32'h0000_005A);
    check("rx_byte2_frame_err", {31'd0, bus.frame_err}, 32'd0);
    drop_cmd();

    // Reset during the start bit of byte 2 of a TX_WORD
    bus.uartc       = UARTC_TX_WORD;
    bus.write_value = 32'h1122_3344;
    wait_cycles(1);                        // accept edge E
    wait_cycles(42);                       // after E+42: byte 2 start bit
    check("mid_word_tx_low", {31'd0, tx}, 32'd0);
    rst       = 1'b1;
    bus.uartc = UARTC_NOP;
    wait_cycles(1);
    check("mid_reset_tx", {31'd0, tx}, 32'd1);
    check("mid_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_reset_wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;
    wait_cycles(2);
    tx_cmd(UARTC_TX_BYTE, 32'h0000_0001, 1);
    check("post_reset_wb_data", bus.wb_data, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_link.md
# uart_link

Peripheral-side UART engine answering the core's 3-bit UART command bus. It accepts a command and a 32-bit write value, serialises bytes onto `tx` or deserialises bytes from `rx` (8N1), and returns completion and received data on `wb_flag`/`wb_data`. It sits between the core's `UARTC`/`UART_out`/`UART_in`/`wb_flag` pins and the physical serial lines, and is the device the core's UART wait-state machine stalls on.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
- `clock`  in  1: single clock; every register in the block uses it.
- `reset`  in  1: synchronous, active-high.
- `uartc`  in  3: command from the core; held stable by the core until `wb_flag` is seen.
- `write_value`  in  32: TX data from the core's `UART_out`; sampled only on command accept.
- `rx`  in  1: serial input, asynchronous, idle high.
- `tx`  out  1: serial output, idle high; reset value 1.
- `wb_flag`  out  1: command complete; reset value 0.
- `wb_data`  out  32: received data, feeds the core's `UART_in`; reset value 0.
- `frame_err`  out  1: a stop bit sampled 0 during the last RX command; reset value 0.
- `busy`  out  1: command in progress (not IDLE); reset value 0.

## Operation
- Command codes: 000 NOP; 001 TX_BYTE (`write_value[7:0]`); 010 RX_BYTE (result in `wb_data[7:0]`, upper bits 0); 011 TX_WORD (4 bytes, `[7:0]` first); 100 RX_WORD (4 bytes, first byte received goes to `[7:0]`). Codes 101–111 behave as NOP.
- States: IDLE, TX_BITS, RX_HUNT, RX_BITS, DONE.
- IDLE: when `uartc` is a valid non-NOP code, latch command, `write_value`, and byte count (1 or 4). Clear `frame_err` on RX commands. Go to TX_BITS or RX_HUNT.
- TX_BITS: frame = start 0, data LSB first, stop 1, each bit held `CLKS_PER_BIT` cycles. Word mode sends bytes back-to-back with no idle gap. After the last stop bit, go to DONE.
- RX path: `rx` passes through a 2-flop synchroniser.
  - RX_HUNT: wait for synchronised `rx` = 0, then count `CLKS_PER_BIT/2` cycles (integer division) and recheck. If 1, treat as a glitch and stay in RX_HUNT. If 0, go to RX_BITS.
  - RX_BITS: sample 8 data bits and the stop bit at `CLKS_PER_BIT` intervals from the start-bit midpoint. A stop bit of 0 sets `frame_err`; the byte is still kept.
  - Word mode returns to RX_HUNT for the next byte. After the last byte, load `wb_data` and go to DONE.
- DONE: `wb_flag` = 1 and holds until `uartc` = 000, then go to IDLE the next cycle. This level handshake prevents a held command from re-triggering.
- `uartc` changes while busy are ignored; only the latched command runs.
- `wb_data` changes only on entry to DONE after an RX command. TX commands leave it unchanged.
- `reset` at any point, including mid-frame: next edge forces IDLE, `tx` = 1, and all outputs to reset values. A partial byte is discarded.

## Timing
- Accept edge E. `tx` falls at E+1, because `tx` is a registered output.
- TX_BYTE: `wb_flag` rises at E+1+10·`CLKS_PER_BIT`. TX_WORD: E+1+40·`CLKS_PER_BIT`.
- RX: first `rx` low seen after 2 synchroniser cycles. Stop bit sampled at start + 9.5·`CLKS_PER_BIT` (+2 for sync). `wb_data` and `wb_flag` update on the edge after the stop sample.
- No RX timeout: RX_HUNT waits indefinitely; only `reset` aborts it.
- `busy` = 1 from E+1 until the cycle IDLE is re-entered.
- `wb_flag` falls on the edge after `uartc` reads 000.
- A new command is accepted no earlier than one cycle after `wb_flag` falls.

## Structure
- `uart_link_pkg`:
  - `uartc` code localparams (`UARTC_NOP`, `UARTC_TX_BYTE`, `UARTC_RX_BYTE`, `UARTC_TX_WORD`, `UARTC_RX_WORD`).
  - The state enum.
  - The core's control unit and MUX_INPUT/DataMem decode share these codes.
- Sub-module `uart_bit_timer`: loadable down-counter (full bit or half bit) with a one-cycle `tick` output. Instantiated once and shared by TX and RX, since only one command runs at a time.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- Reset with `rx` = 1: `tx` = 1, `wb_flag` = 0, `wb_data` = 0, `busy` = 0. Hold `uartc` = 000 for 50 cycles: no activity.
- TX_BYTE with `write_value` = 0x000000A5:
  - `tx` waveform 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `wb_flag` at E+41.
  - Hold `uartc` for 20 more cycles: no second frame.
  - Drop to 000: `wb_flag` clears.
- TX_WORD with 0x11223344: bytes 0x44, 0x33, 0x22, 0x11 contiguous, `wb_flag` at E+161.
- RX_WORD, model drives 0xEF, 0xBE, 0xAD, 0xDE with random 0–7 cycle gaps: `wb_data` = 0xDEADBEEF, `frame_err` = 0.
- RX_BYTE:
  - 1-cycle low glitch: ignored.
  - Then 0x3C with stop bit 0: `wb_data` = 0x0000003C, `frame_err` = 1.
  - Next RX command clears `frame_err`.
- Reset asserted mid-TX_WORD (during byte 2): `tx` = 1 next cycle, `busy` = 0. A following TX_BYTE 0x01 completes normally.
